// File: rtl/magnetron_power_ctrl.sv
// Magnetron cook-state controller with duty-cycled drive over PERIOD_SLOTS tick slots.
// Optional fan run-on after cook completes is enabled by defining MAG_COOLDOWN_EN.
module magnetron_power_ctrl #(
    parameter int PERIOD_SLOTS   = 10,
    parameter int LVL_W          = 4,
    parameter int COOLDOWN_TICKS = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startn,
    input  logic             stopn,
    input  logic             clearn,
    input  logic             door_closed,
    input  logic             timer_done,
    input  logic             tick,
    input  logic [LVL_W-1:0] power_level,
    output logic             mag_on,
    output logic             fan_on,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COOK  = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [LVL_W-1:0] PMAX  = LVL_W'(PERIOD_SLOTS);
    localparam logic [LVL_W-1:0] SLAST = LVL_W'(PERIOD_SLOTS - 1);

    state_t           cur, nxt;
    logic             load;
    logic             start_ok;
    logic [LVL_W-1:0] slot, lvl_q;

    // Stop and an active timer both veto a start, matching the transition priority.
    assign start_ok = !startn && door_closed && stopn && !timer_done;

    always_comb begin
        nxt  = cur;
        load = 1'b0;
        if (!clearn) begin
            nxt = IDLE;
        end else begin
            case (cur)
                IDLE, DONE: if (start_ok) begin
                    nxt  = COOK;
                    load = 1'b1;
                end
                COOK: begin
                    if (timer_done)                  nxt = DONE;
                    else if (!stopn || !door_closed) nxt = PAUSE;
                end
                PAUSE: if (start_ok) nxt = COOK;
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur   <= IDLE;
            slot  <= '0;
            lvl_q <= '0;
        end else begin
            cur <= nxt;
            if (nxt == IDLE || load)
                slot <= '0;
            else if (tick && cur == COOK)
                slot <= (slot == SLAST) ? '0 : slot + 1'b1;
            if (load)
                lvl_q <= (power_level > PMAX) ? PMAX : power_level;
        end
    end

    assign state  = cur;
    assign mag_on = (cur == COOK) && door_closed && (slot < lvl_q);

`ifdef MAG_COOLDOWN_EN
    localparam int CW = (COOLDOWN_TICKS < 1) ? 1 : $clog2(COOLDOWN_TICKS + 1);
    logic [CW-1:0] cd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cd <= '0;
        else if (!clearn)
            cd <= '0;
        else if (cur == COOK && nxt == DONE)
            cd <= CW'(COOLDOWN_TICKS);
        else if (cur == DONE && tick && cd != '0)
            cd <= cd - 1'b1;
    end

    assign fan_on = (cur == COOK) || (cur == PAUSE) || (cur == DONE && cd != '0);
`else
    localparam int unused_cooldown = COOLDOWN_TICKS;
    assign fan_on = (cur == COOK) && door_closed;
`endif

endmodule

// File: tb/tb_magnetron_power_ctrl.sv
// Bench for magnetron_power_ctrl: directed vector table, corner sequences and
// randomized stimulus checked against a cycle-level behavioural model.
module tb_magnetron_power_ctrl;
    localparam int PS = 10;
    localparam int CDT = 5;

    logic       clk, rst;
    logic       startn, stopn, clearn, door_closed, timer_done, tick;
    logic [3:0] power_level;
    logic       mag_on, fan_on;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;

    magnetron_power_ctrl #(.PERIOD_SLOTS(PS), .LVL_W(4), .COOLDOWN_TICKS(CDT)) dut (
        .clk(clk), .rst(rst), .startn(startn), .stopn(stopn), .clearn(clearn),
        .door_closed(door_closed), .timer_done(timer_done), .tick(tick),
        .power_level(power_level), .mag_on(mag_on), .fan_on(fan_on), .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       startn, stopn, clearn, door, timer, tick;
        logic [3:0] pl;
    } in_t;

    typedef struct {
        in_t        i;
        logic [1:0] st;
        logic       mag;
    } vec_t;

    // Behavioural model: 0=IDLE 1=COOK 2=PAUSE 3=DONE
    int m_state, m_slot, m_lvl, m_cd;

    function automatic in_t mk(input logic s, p, c, d, t, k, input logic [3:0] pl);
        in_t v;
        v.startn = s; v.stopn = p; v.clearn = c; v.door = d; v.timer = t; v.tick = k; v.pl = pl;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_mag(input logic door);
        return (m_state == 1 && door && m_slot < m_lvl) ? 1 : 0;
    endfunction

    function automatic int exp_fan(input logic door);
`ifdef MAG_COOLDOWN_EN
        return (m_state == 1 || m_state == 2 || (m_state == 3 && m_cd > 0)) ? 1 : 0;
`else
        return (m_state == 1 && door) ? 1 : 0;
`endif
    endfunction

    task automatic model_step(input in_t v);
        int  ns;
        bit  go;
        bit  load;
        go   = !v.startn && v.door && v.stopn && !v.timer;
        ns   = m_state;
        load = 0;
        if (!v.clearn) ns = 0;
        else if (m_state == 0 || m_state == 3) begin
            if (go) begin ns = 1; load = 1; end
        end else if (m_state == 1) begin
            if (v.timer) ns = 3;
            else if (!v.stopn || !v.door) ns = 2;
        end else if (go) ns = 1;

        if (ns == 0 || load) m_slot = 0;
        else if (v.tick && m_state == 1) m_slot = (m_slot + 1) % PS;
        if (load) m_lvl = (v.pl > PS) ? PS : int'(v.pl);
        if (!v.clearn) m_cd = 0;
        else if (m_state == 1 && ns == 3) m_cd = CDT;
        else if (m_state == 3 && v.tick && m_cd > 0) m_cd = m_cd - 1;
        m_state = ns;
    endtask

    // One clock: drive at negedge, check outputs mid-cycle, advance model at posedge.
    task automatic cyc(input in_t v, output logic [1:0] st_o, output logic mag_o, output logic fan_o);
        @(negedge clk);
        startn = v.startn; stopn = v.stopn; clearn = v.clearn;
        door_closed = v.door; timer_done = v.timer; tick = v.tick; power_level = v.pl;
        #1;
        st_o = state; mag_o = mag_on; fan_o = fan_on;
        check("model_state", int'(state), m_state);
        check("model_mag", int'(mag_on), exp_mag(v.door));
        check("model_fan", int'(fan_on), exp_fan(v.door));
        @(posedge clk);
        model_step(v);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check({name, "_mag"}, int'(mag_on), 0);
        check({name, "_fan"}, int'(fan_on), 0);
        check({name, "_state"}, int'(state), 0);
        m_state = 0; m_slot = 0; m_lvl = 0; m_cd = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t tbl[22];
    in_t  idle, tk;
    logic [1:0] st;
    logic mg, fn;
    int   fan_cnt;

    initial begin
        rst = 1'b1;
        startn = 1; stopn = 1; clearn = 1; door_closed = 1; timer_done = 0; tick = 0; power_level = 0;
        m_state = 0; m_slot = 0; m_lvl = 0; m_cd = 0;
        idle = mk(1, 1, 1, 1, 0, 0, 0);
        tk   = mk(1, 1, 1, 1, 0, 1, 0);

        tbl[0]  = '{mk(0,1,1,1,0,0,3),  2'd0, 1'b0};
        tbl[1]  = '{tk,                 2'd1, 1'b1};
        tbl[2]  = '{tk,                 2'd1, 1'b1};
        tbl[3]  = '{tk,                 2'd1, 1'b1};
        tbl[4]  = '{tk,                 2'd1, 1'b0};
        tbl[5]  = '{idle,               2'd1, 1'b0};
        tbl[6]  = '{mk(1,0,1,1,0,0,0),  2'd1, 1'b0};
        tbl[7]  = '{tk,                 2'd2, 1'b0};
        tbl[8]  = '{mk(0,1,1,1,0,0,9),  2'd2, 1'b0};
        tbl[9]  = '{idle,               2'd1, 1'b0};
        tbl[10] = '{mk(1,0,1,1,1,0,0),  2'd1, 1'b0};
        tbl[11] = '{mk(0,1,1,1,1,0,0),  2'd3, 1'b0};
        tbl[12] = '{mk(0,1,1,1,0,0,15), 2'd3, 1'b0};
        tbl[13] = '{idle,               2'd1, 1'b1};
        tbl[14] = '{mk(0,1,0,1,0,0,0),  2'd1, 1'b1};
        tbl[15] = '{idle,               2'd0, 1'b0};
        tbl[16] = '{mk(0,0,1,1,0,0,5),  2'd0, 1'b0};
        tbl[17] = '{mk(0,1,1,0,0,0,5),  2'd0, 1'b0};
        tbl[18] = '{idle,               2'd0, 1'b0};
        tbl[19] = '{mk(0,1,1,1,0,0,2),  2'd0, 1'b0};
        tbl[20] = '{mk(1,1,1,0,0,1,0),  2'd1, 1'b0};
        tbl[21] = '{idle,               2'd2, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", int'(state), 0);
        check("reset_mag", int'(mag_on), 0);
        check("reset_fan", int'(fan_on), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            cyc(tbl[i].i, st, mg, fn);
            check($sformatf("tbl%0d_state", i), int'(st), int'(tbl[i].st));
            check($sformatf("tbl%0d_mag", i), int'(mg), int'(tbl[i].mag));
        end

        // Door opens in slot 1, then resume from the same slot.
        do_reset("rst_a");
        cyc(mk(0,1,1,1,0,0,3), st, mg, fn);
        cyc(tk, st, mg, fn);
        check("door_pre_mag", int'(mg), 1);
        cyc(mk(1,1,1,0,0,0,0), st, mg, fn);
        check("door_open_mag", int'(mg), 0);
        check("door_open_state", int'(st), 1);
        cyc(idle, st, mg, fn);
        check("door_pause", int'(st), 2);
        cyc(mk(0,1,1,1,0,0,7), st, mg, fn);
        cyc(tk, st, mg, fn);
        check("resume_s1", int'(mg), 1);
        cyc(tk, st, mg, fn);
        check("resume_s2", int'(mg), 1);
        cyc(idle, st, mg, fn);
        check("resume_s3", int'(mg), 0);

        // Zero power: drive never asserts.
        do_reset("rst_b");
        cyc(mk(0,1,1,1,0,0,0), st, mg, fn);
        for (int i = 0; i < 30; i++) begin
            cyc(tk, st, mg, fn);
            check("pl0_mag", int'(mg), 0);
        end
        check("pl0_state", int'(st), 1);

        // Clamped full power: continuous drive across wraps.
        cyc(mk(1,1,0,1,0,0,0), st, mg, fn);
        cyc(mk(0,1,1,1,0,0,15), st, mg, fn);
        for (int i = 0; i < 14; i++) begin
            cyc(tk, st, mg, fn);
            check("pl15_mag", int'(mg), 1);
        end

        // Async reset between edges while the magnetron is on.
        do_reset("rst_mid");

        // Fan run-on after timer completion.
        cyc(mk(0,1,1,1,0,0,4), st, mg, fn);
        cyc(tk, st, mg, fn);
        cyc(mk(1,1,1,1,1,0,0), st, mg, fn);
        fan_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(tk, st, mg, fn);
            check("cd_state", int'(st), 3);
            if (fn) fan_cnt++;
        end
`ifdef MAG_COOLDOWN_EN
        check("cd_fan_ticks", fan_cnt, CDT);
`else
        check("cd_fan_ticks", fan_cnt, 0);
`endif
        cyc(mk(1,1,0,1,0,0,0), st, mg, fn);
        cyc(idle, st, mg, fn);
        check("clear_idle", int'(st), 0);

        // Randomized stimulus against the model.
        for (int i = 0; i < 600; i++) begin
            in_t r;
            r.startn = ($urandom_range(0, 3) != 0);
            r.stopn  = ($urandom_range(0, 7) != 0);
            r.clearn = ($urandom_range(0, 24) != 0);
            r.door   = ($urandom_range(0, 9) != 0);
            r.timer  = ($urandom_range(0, 29) == 0);
            r.tick   = 1'($urandom_range(0, 1));
            r.pl     = 4'($urandom_range(0, 15));
            cyc(r, st, mg, fn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
